data_sram_resp: RTL and testbench

Data-memory responder for the core's data SRAM port. It sits on the far side of the execute stage's `data_sram_*` request signals. It accepts one request per cycle, commits byte-masked writes, and returns read data after a fixed, parameterised latency with a valid strobe. Out-of-range accesses are flagged. Read data is consumed by the memory/writeback path.

---
 rtl/data_sram_resp.sv | 106 ++++++++++
 tb/tb_data_sram_resp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder with byte-masked writes and fixed-latency reads
module data_sram_resp #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              in_range;
    logic              wr_req;
    logic              wr_commit;
    logic [31:0]       old_word;
    logic [31:0]       merged_word;

    logic              iss_v;
    logic              iss_e;
    logic [31:0]       iss_d;

    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_e;
    logic [31:0]       pipe_d [RD_LAT];

    logic [RD_LAT:0]   v_chain;
    logic [RD_LAT:0]   e_chain;
    logic [31:0]       d_chain [RD_LAT+1];

    // Byte offset bits are don't-care: every access is word aligned.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    // Decode the request and form the issue-cycle pipeline entry; reads see the write-first merge.
    always_comb begin
        word_idx    = data_sram_addr[ADDR_W+1:2];
        in_range    = (data_sram_addr[31:ADDR_W+2] == '0);
        wr_req      = |data_sram_wen;
        wr_commit   = reset && wr_req && in_range;
        old_word    = mem[word_idx];
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
        iss_v = data_sram_en;
        iss_e = (data_sram_en || wr_req) && !in_range;
        iss_d = in_range ? merged_word : 32'h0000_0000;
    end

    // Stage inputs: index 0 is the new issue, index i feeds stage i from stage i-1.
    always_comb begin
        v_chain    = {pipe_v, iss_v};
        e_chain    = {pipe_e, iss_e};
        d_chain[0] = iss_d;
        for (int i = 1; i <= RD_LAT; i++) begin
            d_chain[i] = pipe_d[i-1];
        end
    end

    // Commit enabled byte lanes; array contents survive reset, but requests under reset are ignored.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline; data stages load only behind a valid entry so rdata holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= 32'h0000_0000;
            end
        end else begin
            pipe_v <= v_chain[RD_LAT-1:0];
            pipe_e <= e_chain[RD_LAT-1:0];
            for (int i = 0; i < RD_LAT; i++) begin
                if (v_chain[i]) begin
                    pipe_d[i] <= d_chain[i];
                end
            end
        end
    end

    assign data_sram_rvalid = pipe_v[RD_LAT-1];
    assign data_sram_err    = pipe_e[RD_LAT-1];
    assign data_sram_rdata  = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp against a word-level memory model
module tb_data_sram_resp;

    localparam int ADDR_W = 12;
    localparam int LAT    = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXC   = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_sram_en     (en),
        .data_sram_wen    (wen),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata),
        .data_sram_rvalid (rvalid),
        .data_sram_err    (err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_mem [DEPTH];
    bit          exp_v [MAXC];
    bit          exp_e [MAXC];
    logic [31:0] exp_d [MAXC];
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_valid_data = 32'h0;
    int          valid_seen = 0;
    int          err_seen = 0;
    int          pool [$] = '{0, 1, 2, 3, 4, 8, 12, 16, 4095};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic observe();
        logic [31:0] want_d;
        want_d = exp_v[cyc] ? exp_d[cyc] : last_rdata;
        chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v[cyc]});
        chk("err", {31'b0, err}, {31'b0, exp_e[cyc]});
        chk("rdata", rdata, want_d);
        last_rdata = want_d;
        if (rvalid === 1'b1) begin
            valid_seen++;
            last_valid_data = rdata;
        end
        if (err === 1'b1) err_seen++;
    endtask

    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bit          ok;
        int          idx;
        logic [31:0] m;
        en = e; wen = w; addr = a; wdata = d;
        ok  = (a[31:ADDR_W+2] == 0);
        idx = int'(a[ADDR_W+1:2]);
        m   = merge(model_mem[idx], d, w);
        if (e) begin
            exp_v[cyc+LAT] = 1'b1;
            exp_e[cyc+LAT] = !ok;
            exp_d[cyc+LAT] = ok ? m : 32'h0;
        end else if (w != 4'h0 && !ok) begin
            exp_e[cyc+LAT] = 1'b1;
        end
        if (w != 4'h0 && ok) model_mem[idx] = m;
        @(posedge clk);
        cyc++;
        #1;
        observe();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset(input logic [31:0] a);
        reset = 1'b0;
        #1;
        chk("rst_async_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_async_err", {31'b0, err}, 32'h0);
        chk("rst_async_rdata", rdata, 32'h0);
        for (int k = cyc + 1; k < MAXC; k++) begin
            exp_v[k] = 1'b0;
            exp_e[k] = 1'b0;
        end
        last_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            en = 1'b1; wen = 4'hF; addr = a; wdata = $urandom;
            @(posedge clk);
            cyc++;
            #1;
            chk("rst_hold_rvalid", {31'b0, rvalid}, 32'h0);
            chk("rst_hold_rdata", rdata, 32'h0);
        end
        en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        reset = 1'b1;
    endtask

    initial begin
        int          mark_v;
        int          mark_e;
        logic [31:0] ra;
        logic        re;
        logic [3:0]  rw;

        reset = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        reset = 1'b1;

        foreach (pool[i]) step(1'b0, 4'hF, pool[i] * 4, $urandom);

        // basic write then read
        step(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        mark_v = valid_seen;
        step(1'b1, 4'h0, 32'h10, 32'h0);
        idle(LAT);
        chk("basic_pulses", valid_seen - mark_v, 1);
        chk("basic_data", last_valid_data, 32'hDEADBEEF);

        // byte lanes
        step(1'b0, 4'hF, 32'h20, 32'h11223344);
        step(1'b0, 4'b0101, 32'h20, 32'hAABBCCDD);
        step(1'b1, 4'h0, 32'h20, 32'h0);
        idle(LAT);
        chk("lanes_data", last_valid_data, 32'h11BB33DD);

        // simultaneous read and write
        step(1'b0, 4'hF, 32'h30, 32'h0);
        step(1'b1, 4'b1100, 32'h30, 32'hCAFE0000);
        idle(LAT);
        chk("rw_same_cycle", last_valid_data, 32'hCAFE0000);

        // streaming reads
        for (int i = 0; i < 4; i++) step(1'b0, 4'hF, i * 4, i + 1);
        mark_v = valid_seen;
        for (int i = 0; i < 4; i++) step(1'b1, 4'h0, i * 4, 32'h0);
        idle(LAT);
        chk("stream_pulses", valid_seen - mark_v, 4);
        chk("stream_last", last_valid_data, 32'h4);

        // out of range write then read
        mark_v = valid_seen;
        mark_e = err_seen;
        step(1'b0, 4'hF, 32'h00004000, 32'h55AA55AA);
        step(1'b1, 4'h0, 32'h00004000, 32'h0);
        idle(LAT);
        chk("oor_err_pulses", err_seen - mark_e, 2);
        chk("oor_valid_pulses", valid_seen - mark_v, 1);
        chk("oor_rdata", last_valid_data, 32'h0);
        step(1'b1, 4'h0, 32'h0, 32'h0);
        idle(LAT);
        chk("oor_word0_intact", last_valid_data, 32'h1);

        // reset with a read in flight
        mark_v = valid_seen;
        step(1'b1, 4'h0, 32'h8, 32'h0);
        idle(1);
        pulse_reset(32'h8);
        idle(LAT);
        chk("rst_no_stale_pulse", valid_seen - mark_v, 0);
        step(1'b1, 4'h0, 32'h8, 32'h0);
        idle(LAT);
        chk("rst_contents_kept", last_valid_data, 32'h3);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ra = pool[$urandom_range(0, pool.size() - 1)] * 4;
            ra = ra | $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) ra = ra | (32'($urandom_range(1, 7)) << (ADDR_W + 2 + $urandom_range(0, 10)));
            re = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(re, rw, ra, $urandom);
        end
        idle(LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
